// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the cache line reader.
// Widths here are the defaults the reader and its bus interface are built with.
package cache_pkg;

   localparam int LINE_BYTES = 32;
   localparam int OFF_W      = 5;
   localparam int DATA_W     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/cache_line_reader_if.sv
// Request, cache read port and byte stream of the cache line reader, bundled.
// master = requester/cache/consumer side, slave = the reader itself.
interface cache_line_reader_if;
   import cache_pkg::*;

   logic              start;
   logic [OFF_W-1:0]  start_off;
   logic [OFF_W-1:0]  burst_len;
   logic [OFF_W-1:0]  rdoffset;
   logic [DATA_W-1:0] q;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              done;

   modport master (
      output start, start_off, burst_len, q, out_ready,
      input  rdoffset, out_data, out_valid, out_last, busy, done
   );

   modport slave (
      input  start, start_off, burst_len, q, out_ready,
      output rdoffset, out_data, out_valid, out_last, busy, done
   );

endinterface

// File: rtl/byte_fifo2.sv
// Two-entry byte FIFO; the head is presented combinationally and reads as zero when empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module byte_fifo2 #(
   parameter int DATA_W = cache_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem_reg [2];
   logic              wr_ptr_reg;
   logic              rd_ptr_reg;
   logic [1:0]        count_reg;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop && (count_reg != 2'd0);
   assign do_push = push && ((count_reg != 2'd2) || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= push_data;
   end

   assign empty = (count_reg == 2'd0);
   assign full  = (count_reg == 2'd2);
   assign count = count_reg;
   assign head  = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/cache_line_reader.sv
// Streams a wrapped burst of bytes out of one cache line through a 2-entry FIFO.
// The read port is synchronous: q returns one cycle after rdoffset is presented.
module cache_line_reader #(
   parameter int LINE_BYTES = cache_pkg::LINE_BYTES,
   parameter int OFF_W      = cache_pkg::OFF_W,
   parameter int DATA_W     = cache_pkg::DATA_W
) (
   input logic                clk,
   input logic                rst,
   cache_line_reader_if.slave bus
);
   import cache_pkg::*;

   state_t            state_reg;
   state_t            state_next;
   logic [OFF_W-1:0]  hold_off_reg;
   logic [OFF_W-1:0]  next_off_reg;
   logic [OFF_W:0]    len_reg;
   logic [OFF_W:0]    remaining_reg;
   logic [OFF_W:0]    xfer_cnt_reg;
   logic              in_flight_reg;

   logic [OFF_W:0]    start_len;
   logic [OFF_W-1:0]  issue_off;
   logic [OFF_W-1:0]  issue_off_inc;
   logic              accept;
   logic              credit_ok;
   logic              issue;
   logic              pop;
   logic              last_xfer;

   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [1:0]        fifo_count;

   assign start_len = (bus.burst_len == '0) ? (OFF_W+1)'(LINE_BYTES) : {1'b0, bus.burst_len};
   assign accept    = !rst && (state_reg == IDLE) && bus.start;
   assign pop       = bus.out_valid && bus.out_ready;
   assign last_xfer = pop && bus.out_last;

   // A byte leaving the FIFO this cycle frees the slot a new read would need.
   assign credit_ok = pop || (({1'b0, fifo_count} + {2'b00, in_flight_reg}) < 3'd2);

   // The first read goes out with the accepting start so data appears two cycles later.
   assign issue = accept ||
                  (!rst && (state_reg == READ) && (remaining_reg != '0) && credit_ok);

   assign issue_off     = (state_reg == IDLE) ? bus.start_off : next_off_reg;
   assign issue_off_inc = (issue_off == OFF_W'(LINE_BYTES - 1)) ? '0 : issue_off + 1'b1;

   byte_fifo2 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_flight_reg),
      .push_data (bus.q),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = READ;
         READ:    if (remaining_reg == '0) state_next = DRAIN;
         DRAIN:   if (last_xfer) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy      = (state_reg != IDLE);
      bus.done      = (state_reg == DONE);
      bus.out_valid = !fifo_empty;
      bus.out_data  = fifo_head;
      bus.out_last  = !fifo_empty && (xfer_cnt_reg == len_reg - 1'b1);
      bus.rdoffset  = issue ? issue_off : hold_off_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_off_reg  <= '0;
         next_off_reg  <= '0;
         len_reg       <= '0;
         remaining_reg <= '0;
         xfer_cnt_reg  <= '0;
         in_flight_reg <= 1'b0;
      end else begin
         in_flight_reg <= issue;
         if (issue) begin
            hold_off_reg <= issue_off;
            next_off_reg <= issue_off_inc;
         end
         if (accept) begin
            len_reg       <= start_len;
            remaining_reg <= start_len - 1'b1;
            xfer_cnt_reg  <= '0;
         end else begin
            if (issue) remaining_reg <= remaining_reg - 1'b1;
            if (pop)   xfer_cnt_reg  <= xfer_cnt_reg + 1'b1;
         end
      end
   end

   // The read credit keeps returning data from ever meeting a full FIFO.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(in_flight_reg && fifo_full && !pop));
      end
   end

endmodule

// File: tb/tb_cache_line_reader.sv
// Directed bench for cache_line_reader: a transaction-level byte queue model checks the
// stream every cycle; literal expectations per burst pin ordering, latency and done timing.
module tb_cache_line_reader;
   import cache_pkg::*;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_line_reader_if bus ();

   cache_line_reader #(
      .LINE_BYTES (LINE_BYTES),
      .OFF_W      (OFF_W),
      .DATA_W     (DATA_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Synchronous cache line: q follows rdoffset by one cycle.
   logic [DATA_W-1:0] line_mem [LINE_BYTES];
   always @(posedge clk) bus.q <= line_mem[bus.rdoffset];

   int tests_run = 0;
   int fails     = 0;
   int cyc       = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---- model state and transfer log ----
   exp_t              exp_q [$];
   exp_t              e;
   logic              busy_exp   = 1'b0;
   logic              done_exp   = 1'b0;
   logic              after_rst  = 1'b0;
   logic              prev_stall = 1'b0;
   logic              nb;
   logic              nd;
   int                start_cyc  = 0;
   int                blen;
   logic [DATA_W-1:0] tx_data [$];
   logic              tx_last [$];
   int                tx_cyc  [$];
   int                done_cnt = 0;
   int                done_cyc = 0;
   int                ready_mode = 0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         busy_exp   = 1'b0;
         done_exp   = 1'b0;
         prev_stall = 1'b0;
         after_rst  = 1'b1;
      end else begin
         if (after_rst) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_last",  bus.out_last,  0);
            check("rst_busy",      bus.busy,      0);
            check("rst_done",      bus.done,      0);
            check("rst_rdoffset",  bus.rdoffset,  0);
            check("rst_out_data",  bus.out_data,  0);
            after_rst = 1'b0;
         end
         check("busy", bus.busy, busy_exp);
         check("done", bus.done, done_exp);
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         nd = 1'b0;
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("extra_byte", bus.out_valid, 0);
            end else begin
               check("out_data", bus.out_data, exp_q[0].data);
               check("out_last", bus.out_last, exp_q[0].last);
               if (bus.out_ready) begin
                  tx_data.push_back(bus.out_data);
                  tx_last.push_back(bus.out_last);
                  tx_cyc.push_back(cyc);
                  nd = exp_q[0].last;
                  void'(exp_q.pop_front());
               end
            end
         end else if (prev_stall) begin
            check("valid_held", bus.out_valid, 1);
         end
         prev_stall = bus.out_valid && !bus.out_ready;

         nb = busy_exp;
         if (done_exp) nb = 1'b0;
         if (bus.start && !busy_exp) begin
            blen = (bus.burst_len == 0) ? LINE_BYTES : int'(bus.burst_len);
            for (int i = 0; i < blen; i++) begin
               e.data = line_mem[(int'(bus.start_off) + i) % LINE_BYTES];
               e.last = (i == blen - 1);
               exp_q.push_back(e);
            end
            start_cyc = cyc;
            nb = 1'b1;
         end
         busy_exp = nb;
         done_exp = nd;
      end
   end

   // Consumer: always ready, or the 1,0,0,1 stall pattern.
   initial begin
      int k;
      k = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) begin
            bus.out_ready = 1'b1;
         end else begin
            bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            k++;
         end
      end
   end

   task automatic clear_log();
      tx_data.delete();
      tx_last.delete();
      tx_cyc.delete();
      done_cnt = 0;
   endtask

   task automatic do_start(input int off, input int len);
      @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.start_off = OFF_W'(off);
      bus.burst_len = OFF_W'(len);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt > 0) break;
      end
      check({name, "_done_seen"}, (done_cnt > 0), 1);
   endtask

   task automatic check_seq(input string name, input int off, input int len);
      check({name, "_count"}, tx_data.size(), len);
      if (tx_data.size() == len) begin
         for (int i = 0; i < len; i++) begin
            check({name, "_data"}, tx_data[i], (off + i) % LINE_BYTES);
            check({name, "_last"}, tx_last[i], (i == len - 1));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < LINE_BYTES; i++) line_mem[i] = DATA_W'(i);
      bus.start     = 1'b0;
      bus.start_off = '0;
      bus.burst_len = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Full line from offset 0 with continuous ready.
      clear_log();
      do_start(0, 0);
      wait_done(100, "t1");
      check_seq("t1", 0, 32);
      if (tx_data.size() == 32) begin
         check("t1_first_byte", tx_data[0], 8'h00);
         check("t1_last_byte",  tx_data[31], 8'h1F);
         check("t1_latency",    tx_cyc[0] - start_cyc, 2);
         check("t1_throughput", tx_cyc[31] - tx_cyc[0], 31);
         check("t1_done_after", done_cyc - tx_cyc[31], 1);
      end

      // Wrapping burst, started in the very first idle cycle after done.
      clear_log();
      do_start(30, 4);
      wait_done(40, "t2");
      check_seq("t2", 30, 4);
      if (tx_data.size() == 4) begin
         check("t2_b0", tx_data[0], 8'h1E);
         check("t2_b1", tx_data[1], 8'h1F);
         check("t2_b2", tx_data[2], 8'h00);
         check("t2_b3", tx_data[3], 8'h01);
      end

      // Stalling consumer.
      clear_log();
      ready_mode = 1;
      do_start(10, 8);
      wait_done(100, "t3");
      ready_mode = 0;
      check_seq("t3", 10, 8);

      // Single byte.
      clear_log();
      do_start(5, 1);
      wait_done(40, "t4");
      check_seq("t4", 5, 1);
      if (tx_data.size() == 1) begin
         check("t4_byte",       tx_data[0], 8'h05);
         check("t4_done_after", done_cyc - tx_cyc[0], 1);
      end
      @(negedge clk);
      check("t4_busy_low", bus.busy, 0);

      // Reset after the third transfer of a 16-byte burst, then a fresh burst.
      clear_log();
      do_start(0, 16);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (tx_data.size() >= 3) break;
      end
      check("t5_three_xfers", tx_data.size(), 3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_no_done", done_cnt, 0);
      check("t5_idle", bus.busy, 0);
      clear_log();
      do_start(3, 5);
      wait_done(40, "t5b");
      check_seq("t5b", 3, 5);

      // Start while busy is ignored.
      clear_log();
      do_start(0, 6);
      @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.start_off = OFF_W'(20);
      bus.burst_len = OFF_W'(2);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(40, "t6");
      check_seq("t6", 0, 6);
      repeat (5) @(negedge clk);
      check("t6_single_done", done_cnt, 1);
      check("t6_no_restart", bus.busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
